// File: rtl/isa_dma_arbiter_if.sv
// Bus-side signal bundle of the ISA DMA arbiter: DRQ/DACK pins, PIO handshake,
// cycle-engine handshake and debug state. The arbiter uses "master", the
// surrounding logic (PIO side, cycle engine, pads) uses "slave".
interface isa_dma_arbiter_if;
  logic [3:0] drq_in;
  logic [3:0] chan_en;
  logic [3:0] chan_dir;
  logic       pio_req;
  logic       pio_done;
  logic       pio_grant;
  logic       cyc_req;
  logic       cyc_dir;
  logic [1:0] cyc_chan;
  logic       cyc_done;
  logic [3:0] dack_n;
  logic       aen;
  logic       dma_err;
  logic [3:0] state_out;

  modport master (
    input  drq_in, chan_en, chan_dir, pio_req, pio_done, cyc_done,
    output pio_grant, cyc_req, cyc_dir, cyc_chan, dack_n, aen, dma_err, state_out
  );

  modport slave (
    output drq_in, chan_en, chan_dir, pio_req, pio_done, cyc_done,
    input  pio_grant, cyc_req, cyc_dir, cyc_chan, dack_n, aen, dma_err, state_out
  );
endinterface

// File: rtl/isa_dma_arbiter.sv
// ISA bus arbiter: shares the bus between PIO cycles and four DMA channels,
// round-robin among DRQs, alternating with PIO when both are pending.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | bus free, one arbitration decision per clock
// PIO     | bus lent to the PIO side until pio_done
// SETUP   | DACK/AEN asserted, counting setup clocks before cyc_req
// XFER    | cyc_req high, waiting for cyc_done or timeout
// RECOVER | DACK/AEN released, idle clocks before re-arbitration
module isa_dma_arbiter #(
  parameter int SYNC_STAGES     = 2,
  parameter int SETUP_CYCLES    = 4,
  parameter int RECOVERY_CYCLES = 8,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                  clk,
  input  logic                  reset_n,
  isa_dma_arbiter_if.master     bus
);

  localparam int CMAX_A = (SETUP_CYCLES > RECOVERY_CYCLES) ? SETUP_CYCLES : RECOVERY_CYCLES;
  localparam int CMAX   = (CMAX_A > TIMEOUT_CYCLES) ? CMAX_A : TIMEOUT_CYCLES;
  localparam int CW     = $clog2(CMAX + 1);

  localparam logic [CW-1:0] SETUP_LOAD   = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] RECOVER_LOAD = CW'(RECOVERY_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PIO     = 3'd1,
    S_SETUP   = 3'd2,
    S_XFER    = 3'd3,
    S_RECOVER = 3'd4
  } state_t;

  state_t                         state_q, state_d;
  logic [SYNC_STAGES-1:0][3:0]    sync_q;
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic [1:0]                     chan_q, chan_d;
  logic                           dir_q, dir_d;
  logic [1:0]                     rr_ptr_q, rr_ptr_d;
  logic                           last_dma_q, last_dma_d;
  logic                           err_q, err_d;

  logic [3:0] drq_s;
  logic [3:0] cand;
  logic       pick_valid;
  logic [1:0] pick_ch;
  logic [1:0] idx;
  logic       own;

  assign drq_s = sync_q[SYNC_STAGES-1];
  assign cand  = drq_s & bus.chan_en;

  // DRQ synchronizer shift chain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], bus.drq_in};
  end

  // Round-robin pick: first candidate strictly after the last granted channel
  always_comb begin
    pick_valid = 1'b0;
    pick_ch    = 2'd0;
    idx        = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      idx = rr_ptr_q + 2'(i);
      if (!pick_valid && cand[idx]) begin
        pick_valid = 1'b1;
        pick_ch    = idx;
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      chan_q     <= 2'd0;
      dir_q      <= 1'b0;
      rr_ptr_q   <= 2'd3;
      last_dma_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      chan_q     <= chan_d;
      dir_q      <= dir_d;
      rr_ptr_q   <= rr_ptr_d;
      last_dma_q <= last_dma_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic; one shared down-counter serves setup, timeout and recovery
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    chan_d     = chan_q;
    dir_d      = dir_q;
    rr_ptr_d   = rr_ptr_q;
    last_dma_d = last_dma_q;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        // PIO only yields to DMA right after its own turn
        if (bus.pio_req && (last_dma_q || cand == 4'd0)) begin
          state_d = S_PIO;
        end else if (pick_valid) begin
          chan_d   = pick_ch;
          dir_d    = bus.chan_dir[pick_ch];
          rr_ptr_d = pick_ch;
          cnt_d    = SETUP_LOAD;
          state_d  = S_SETUP;
        end
      end
      S_PIO: begin
        if (bus.pio_done) begin
          last_dma_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      S_SETUP: begin
        if (!drq_s[chan_q] || !bus.chan_en[chan_q]) begin
          err_d   = 1'b1;
          cnt_d   = RECOVER_LOAD;
          state_d = S_RECOVER;
        end else if (cnt_q == '0) begin
          cnt_d   = TIMEOUT_LOAD;
          state_d = S_XFER;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_XFER: begin
        if (bus.cyc_done) begin
          cnt_d   = RECOVER_LOAD;
          state_d = S_RECOVER;
        end else if (cnt_q == '0) begin
          err_d   = 1'b1;
          cnt_d   = RECOVER_LOAD;
          state_d = S_RECOVER;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RECOVER: begin
        if (cnt_q == '0) begin
          last_dma_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus outputs decoded from registered state only
  always_comb begin
    own            = (state_q == S_SETUP) || (state_q == S_XFER);
    bus.dack_n     = own ? ~(4'b0001 << chan_q) : 4'hF;
    bus.aen        = own;
    bus.cyc_req    = (state_q == S_XFER);
    bus.pio_grant  = (state_q == S_PIO);
    bus.cyc_chan   = chan_q;
    bus.cyc_dir    = dir_q;
    bus.dma_err    = err_q;
    bus.state_out  = {1'b0, state_q};
  end

endmodule

// File: tb/tb_isa_dma_arbiter.sv
// Directed bench for isa_dma_arbiter with default parameters.
module tb_isa_dma_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   viol   = 0;

  isa_dma_arbiter_if bus();

  isa_dma_arbiter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    else n_pass++;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [3:0] s, input string tag);
    int n = 0;
    while (bus.state_out !== s && n < 2000) begin
      tick(1);
      n++;
    end
    check(tag, 32'(bus.state_out), 32'(s));
  endtask

  // Bus rules: at most one DACK low, none while PIO owns the bus
  always @(negedge clk) begin
    if (!(bus.dack_n inside {4'hF, 4'hE, 4'hD, 4'hB, 4'h7})) viol++;
    if (bus.pio_grant && bus.dack_n != 4'hF) viol++;
  end

  logic [1:0] rr_exp_ch  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic       rr_exp_dir [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    bus.drq_in   = 4'h0;
    bus.chan_en  = 4'hF;
    bus.chan_dir = 4'h0;
    bus.pio_req  = 1'b0;
    bus.pio_done = 1'b0;
    bus.cyc_done = 1'b0;
    tick(2);
    check("rst_state", 32'(bus.state_out), 0);
    check("rst_dack",  32'(bus.dack_n), 32'hF);
    check("rst_aen",   32'(bus.aen), 0);
    check("rst_grant", 32'(bus.pio_grant), 0);
    check("rst_req",   32'(bus.cyc_req), 0);
    check("rst_err",   32'(bus.dma_err), 0);
    reset_n = 1'b1;
    tick(1);

    // single transfer on channel 0
    bus.drq_in = 4'b0001;
    tick(2);
    check("sync_idle", 32'(bus.state_out), 0);
    tick(1);
    check("t1_setup", 32'(bus.state_out), 2);
    check("t1_dack",  32'(bus.dack_n), 32'hE);
    check("t1_aen",   32'(bus.aen), 1);
    check("t1_noreq", 32'(bus.cyc_req), 0);
    tick(3);
    check("t1_setup3", 32'(bus.state_out), 2);
    tick(1);
    check("t1_xfer", 32'(bus.state_out), 3);
    check("t1_req",  32'(bus.cyc_req), 1);
    check("t1_chan", 32'(bus.cyc_chan), 0);
    check("t1_dir",  32'(bus.cyc_dir), 0);
    bus.drq_in   = 4'b0000;
    bus.cyc_done = 1'b1;
    tick(1);
    bus.cyc_done = 1'b0;
    check("t1_recover", 32'(bus.state_out), 4);
    check("t1_req_off", 32'(bus.cyc_req), 0);
    check("t1_dack_off", 32'(bus.dack_n), 32'hF);
    check("t1_aen_off", 32'(bus.aen), 0);
    tick(7);
    check("t1_recover7", 32'(bus.state_out), 4);
    tick(1);
    check("t1_idle", 32'(bus.state_out), 0);

    // round robin with all DRQs held, from a fresh reset
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    bus.chan_dir = 4'b1010;
    bus.drq_in   = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_state(3, "rr_xfer");
      check("rr_chan", 32'(bus.cyc_chan), 32'(rr_exp_ch[k]));
      check("rr_dir",  32'(bus.cyc_dir), 32'(rr_exp_dir[k]));
      tick(2);
      bus.cyc_done = 1'b1;
      tick(1);
      bus.cyc_done = 1'b0;
      check("rr_recover", 32'(bus.state_out), 4);
    end
    bus.drq_in = 4'b0000;
    wait_state(0, "rr_idle");

    // PIO, then DMA wins against a held pio_req, then PIO again
    bus.pio_req = 1'b1;
    tick(1);
    check("p_pio", 32'(bus.state_out), 1);
    check("p_grant", 32'(bus.pio_grant), 1);
    bus.drq_in = 4'b0100;
    tick(3);
    check("p_hold", 32'(bus.state_out), 1);
    check("p_dack", 32'(bus.dack_n), 32'hF);
    bus.pio_done = 1'b1;
    tick(1);
    bus.pio_done = 1'b0;
    check("p_idle", 32'(bus.state_out), 0);
    check("p_grant_off", 32'(bus.pio_grant), 0);
    tick(1);
    check("p_dma_first", 32'(bus.state_out), 2);
    check("p_chan2", 32'(bus.cyc_chan), 2);
    wait_state(3, "p_xfer");
    bus.drq_in = 4'b0000;
    tick(2);
    bus.cyc_done = 1'b1;
    tick(1);
    bus.cyc_done = 1'b0;
    wait_state(1, "p_pio_again");
    check("p_grant2", 32'(bus.pio_grant), 1);
    check("p_dack2", 32'(bus.dack_n), 32'hF);
    check("p_aen2", 32'(bus.aen), 0);
    bus.pio_req  = 1'b0;
    bus.pio_done = 1'b1;
    tick(1);
    bus.pio_done = 1'b0;
    check("p_done_idle", 32'(bus.state_out), 0);

    // timeout on channel 1
    bus.drq_in = 4'b0010;
    wait_state(3, "to_xfer");
    check("to_chan", 32'(bus.cyc_chan), 1);
    tick(1023);
    check("to_still", 32'(bus.state_out), 3);
    check("to_req_on", 32'(bus.cyc_req), 1);
    check("to_no_err", 32'(bus.dma_err), 0);
    tick(1);
    check("to_recover", 32'(bus.state_out), 4);
    check("to_req_off", 32'(bus.cyc_req), 0);
    check("to_err", 32'(bus.dma_err), 1);
    bus.drq_in = 4'b0000;
    tick(1);
    check("to_err_pulse", 32'(bus.dma_err), 0);
    tick(6);
    check("to_recover7", 32'(bus.state_out), 4);
    tick(1);
    check("to_idle", 32'(bus.state_out), 0);

    // DRQ dropped during SETUP
    bus.drq_in = 4'b0010;
    wait_state(2, "ab_setup");
    bus.drq_in = 4'b0000;
    tick(2);
    check("ab_in_setup", 32'(bus.state_out), 2);
    check("ab_dack", 32'(bus.dack_n), 32'hD);
    check("ab_noreq", 32'(bus.cyc_req), 0);
    tick(1);
    check("ab_recover", 32'(bus.state_out), 4);
    check("ab_err", 32'(bus.dma_err), 1);
    check("ab_dack_off", 32'(bus.dack_n), 32'hF);
    check("ab_noreq2", 32'(bus.cyc_req), 0);
    tick(1);
    check("ab_err_pulse", 32'(bus.dma_err), 0);
    wait_state(0, "ab_idle");

    // asynchronous reset during XFER
    bus.drq_in = 4'b1000;
    wait_state(3, "rx_xfer");
    check("rx_chan", 32'(bus.cyc_chan), 3);
    #2;
    reset_n = 1'b0;
    #1;
    check("rx_dack", 32'(bus.dack_n), 32'hF);
    check("rx_aen", 32'(bus.aen), 0);
    check("rx_req", 32'(bus.cyc_req), 0);
    check("rx_state", 32'(bus.state_out), 0);
    bus.drq_in = 4'b1111;
    @(negedge clk);
    reset_n = 1'b1;
    wait_state(2, "rx_setup");
    check("rx_first_ch0", 32'(bus.cyc_chan), 0);

    check("dack_rules", 32'(viol), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/isa_dma_arbiter.md
Name: isa_dma_arbiter

Overview:
- Sequences the shared ISA bus between HPS-initiated programmed-I/O cycles and the four ISA DMA channels (DRQ1/3/5/7 mapped to channel index 0..3).
- Synchronizes the DRQ inputs and arbitrates among them round-robin.
- Drives the active-low DACK strobes and AEN, and hands each granted transfer to the ISA cycle engine over a req/done handshake.
- Sits inside the ISA SuperIO component, between the Avalon-side PIO logic and the bus cycle engine.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the DRQ synchronizer (min 2).
- SETUP_CYCLES, 4, clocks of DACK/AEN asserted before cyc_req (min 1).
- RECOVERY_CYCLES, 8, idle clocks after each DMA transfer before re-arbitration (min 1).
- TIMEOUT_CYCLES, 1024, max clocks waiting for cyc_done before abort.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- drq_in  in  4  raw DRQ lines, active-high, asynchronous to clk
- chan_en  in  4  per-channel DMA enable, quasi-static
- chan_dir  in  4  per-channel direction: 1 = memory->I/O (IOW), 0 = I/O->memory (IOR)
- pio_req  in  1  PIO cycle wanted, level, held until granted
- pio_done  in  1  one-clock pulse: PIO cycle complete
- pio_grant  out  1  bus owned by PIO side
- cyc_req  out  1  DMA transfer request to cycle engine, level
- cyc_dir  out  1  direction for current DMA transfer
- cyc_chan  out  2  channel index of current DMA transfer
- cyc_done  in  1  one-clock pulse: cycle engine finished
- dack_n  out  4  DACK1/3/5/7, active-low, one-hot-low
- aen  out  1  ISA AEN, high during DMA ownership
- dma_err  out  1  one-clock pulse on timeout or abort
- state_out  out  4  current state encoding, for debug

Behaviour:
- Reset (asynchronous, immediate, also mid-operation):
  - Outputs: dack_n=4'hF, aen=0, pio_grant=0, cyc_req=0, cyc_dir=0, cyc_chan=0, dma_err=0, state_out=0.
  - Internal: rr_ptr=3, so channel 0 has first priority; last_was_dma=0; synchronizer cleared.
- Synchronizer: drq_s = drq_in delayed SYNC_STAGES flops. cand = drq_s & chan_en.
- States and state_out encoding: IDLE=0, PIO=1, SETUP=2, XFER=3, RECOVER=4. Other codes are unreachable; on entry to one, go to IDLE.
- IDLE arbitration, one decision per clock:
  - If pio_req and (last_was_dma or cand==0): go to PIO.
  - Else if cand!=0: ch = first set bit of cand searching upward from rr_ptr+1 (mod 4); latch ch into cyc_chan and chan_dir[ch] into cyc_dir; set rr_ptr=ch; go to SETUP.
  - Else stay in IDLE.
- PIO:
  - pio_grant=1 from the first clock in the state. aen=0, dack_n=F.
  - On pio_done: pio_grant=0 next clock, last_was_dma=0, go to IDLE.
  - No timeout on the PIO side.
- SETUP:
  - dack_n[cyc_chan]=0, aen=1. Counter counts SETUP_CYCLES clocks, then go to XFER with cyc_req=1.
  - If drq_s[cyc_chan]==0 or chan_en[cyc_chan]==0 during SETUP: abort to RECOVER, pulse dma_err, never raise cyc_req.
- XFER:
  - cyc_req=1, dack_n and aen held. Timeout counter starts at 0.
  - On cyc_done: cyc_req=0 next clock, go to RECOVER.
  - If the counter reaches TIMEOUT_CYCLES-1 without cyc_done: cyc_req=0, pulse dma_err, go to RECOVER.
  - cyc_done outside XFER is ignored.
- RECOVER:
  - dack_n=F and aen=0 on entry. Hold RECOVERY_CYCLES clocks, then go to IDLE with last_was_dma=1.
- Boundary rules:
  - pio_req and DRQ simultaneous in IDLE: alternate. PIO wins after a DMA, DMA wins after a PIO.
  - A channel still asserting DRQ is re-served only after every other pending enabled channel has had a grant.
  - Never more than one dack_n low. dack_n is never low while pio_grant=1.
  - cyc_chan and cyc_dir are stable from SETUP entry to RECOVER exit.

Test Plan:
- Reset, then drq_in=4'b0001, chan_en=F, chan_dir=0 -> after SYNC_STAGES+1 clocks, state=2 and dack_n=4'b1110, aen=1. After 4 clocks, cyc_req=1 with cyc_chan=0, cyc_dir=0. cyc_done -> cyc_req=0, dack_n=F, then 8 idle clocks, then state=0.
- drq_in=4'b1111 held, cyc_done returned 3 clocks after each cyc_req -> grant order 0,1,2,3,0. No two dack_n bits ever low at once.
- pio_req=1 together with drq_in=4'b0100 from IDLE after a PIO -> DMA channel 2 served first, then PIO (pio_grant=1, dack_n=F). pio_done -> IDLE.
- In XFER, cyc_done withheld -> at 1024 clocks, dma_err pulses once, cyc_req drops, state goes to RECOVER then IDLE.
- drq_in[1] deasserted 2 clocks into SETUP for channel 1 -> cyc_req never asserted, dma_err pulse, dack_n=F.
- reset_n pulled low during XFER -> same clock: dack_n=F, aen=0, cyc_req=0, state_out=0. After release, channel 0 has first priority.
